// File: rtl/common_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : common_types_pkg                                        |
// | Description : Shared types and command bytes for the RAM debug loader |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package common_types_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        COUNT = 3'd2,
        WDATA = 3'd3,
        WREQ  = 3'd4,
        RREQ  = 3'd5,
        RSEND = 3'd6,
        RUN   = 3'd7
    } loader_state_t;

    localparam logic [7:0] LDR_CMD_WRITE = 8'h57;
    localparam logic [7:0] LDR_CMD_READ  = 8'h52;
    localparam logic [7:0] LDR_CMD_GO    = 8'h47;
    localparam logic [7:0] LDR_CMD_HALT  = 8'h48;

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : byte_assembler                                          |
// | Description : Little-endian 4-byte collector with a last-byte pulse   |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module byte_assembler (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        done
);

    logic [31:0] r_sr;
    logic [1:0]  r_idx;

    // Bytes enter at the top, so after four shifts byte 0 sits at [7:0].
    assign word_next = {data, r_sr[31:8]};
    assign done      = en && (r_idx == 2'd3);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sr  <= '0;
            r_idx <= '0;
        end else if (en) begin
            r_sr  <= word_next;
            r_idx <= r_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_loader                                              |
// | Description : Byte-stream loader owning the RAM debug/override port   |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module ram_loader
    import common_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              override_ctrl,
    output logic              iren,
    output logic [ADDR_W-1:0] iaddr,
    output logic              dren,
    output logic              dwen,
    output logic [ADDR_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic              dwait,
    input  logic [WORD_W-1:0] dload,
    output logic              cpu_nrst,
    output logic              err
);

    localparam logic [ADDR_W-1:0] c_word_bytes = ADDR_W'(4);

    loader_state_t     r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_is_read;
    logic [WORD_W-1:0] r_shift;
    logic [1:0]        r_tx_idx;

    logic              w_fire;
    logic              w_asm_en;
    logic              w_done;
    logic [31:0]       w_word;
    logic [CNT_W-1:0]  w_count_dec;

    assign rx_ready    = (r_state != WREQ) && (r_state != RREQ) && (r_state != RSEND);
    assign w_fire      = rx_valid && rx_ready;
    assign w_asm_en    = w_fire && ((r_state == ADDR) || (r_state == COUNT) || (r_state == WDATA));
    assign w_count_dec = r_count - CNT_W'(1);
    assign iren        = 1'b0;
    assign iaddr       = '0;

    byte_assembler u_asm (
        .clk       (clk),
        .nrst      (nrst),
        .en        (w_asm_en),
        .data      (rx_data),
        .word_next (w_word),
        .done      (w_done)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            override_ctrl <= 1'b1;
            cpu_nrst      <= 1'b0;
            dren          <= 1'b0;
            dwen          <= 1'b0;
            daddr         <= '0;
            dstore        <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            err           <= 1'b0;
            r_count       <= '0;
            r_is_read     <= 1'b0;
            r_shift       <= '0;
            r_tx_idx      <= '0;
        end else begin
            case (r_state)
                IDLE, RUN: begin
                    if (w_fire) begin
                        if (rx_data == LDR_CMD_HALT) begin
                            override_ctrl <= 1'b1;
                            cpu_nrst      <= 1'b0;
                            r_state       <= IDLE;
                        end else if (r_state == IDLE && rx_data == LDR_CMD_WRITE) begin
                            r_is_read <= 1'b0;
                            r_state   <= ADDR;
                        end else if (r_state == IDLE && rx_data == LDR_CMD_READ) begin
                            r_is_read <= 1'b1;
                            r_state   <= ADDR;
                        end else if (r_state == IDLE && rx_data == LDR_CMD_GO) begin
                            override_ctrl <= 1'b0;
                            cpu_nrst      <= 1'b1;
                            r_state       <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (w_done) begin
                        daddr   <= w_word[ADDR_W-1:0];
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (w_done) begin
                        r_count <= w_word[CNT_W-1:0];
                        if (w_word[CNT_W-1:0] == '0) begin
                            r_state <= IDLE;
                        end else if (r_is_read) begin
                            dren    <= 1'b1;
                            r_state <= RREQ;
                        end else begin
                            r_state <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (w_done) begin
                        dstore  <= w_word[WORD_W-1:0];
                        dwen    <= 1'b1;
                        r_state <= WREQ;
                    end
                end
                WREQ: begin
                    if (!dwait) begin
                        dwen    <= 1'b0;
                        daddr   <= daddr + c_word_bytes;
                        r_count <= w_count_dec;
                        r_state <= (w_count_dec == '0) ? IDLE : WDATA;
                    end
                end
                RREQ: begin
                    if (!dwait) begin
                        dren     <= 1'b0;
                        r_shift  <= dload;
                        tx_data  <= dload[7:0];
                        tx_valid <= 1'b1;
                        r_tx_idx <= '0;
                        daddr    <= daddr + c_word_bytes;
                        r_count  <= w_count_dec;
                        r_state  <= RSEND;
                    end
                end
                RSEND: begin
                    if (tx_ready) begin
                        if (r_tx_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            if (r_count == '0) begin
                                r_state <= IDLE;
                            end else begin
                                dren    <= 1'b1;
                                r_state <= RREQ;
                            end
                        end else begin
                            r_tx_idx <= r_tx_idx + 2'd1;
                            r_shift  <= r_shift >> 8;
                            tx_data  <= r_shift[15:8];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ram_loader                                           |
// | Description : Self-checking bench for ram_loader with a RAM model     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b0;
    logic        dwait = 1'b0;
    logic [31:0] dload = 32'h0;
    logic        rx_ready, tx_valid, override_ctrl, iren, dren, dwen, cpu_nrst, err;
    logic [7:0]  tx_data;
    logic [31:0] iaddr, daddr, dstore;

    ram_loader #(.ADDR_W(32), .WORD_W(32), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .override_ctrl(override_ctrl), .iren(iren), .iaddr(iaddr),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .cpu_nrst(cpu_nrst), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cfg = 0;
    int          wait_left = 0;
    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] wq[$];
    wr_t         obs_w[$], exp_w[$];
    logic [7:0]  obs_tx[$], exp_tx[$];
    logic        prev_tv = 1'b0, prev_tr = 1'b0;
    logic [7:0]  prev_td = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM side: programmable wait states, write capture, read data, tx sink.
    always @(negedge clk) begin
        if (!nrst) begin
            dwait     = 1'b0;
            wait_left = wait_cfg;
            prev_tv   = 1'b0;
        end else begin
            if (dwen || dren) begin
                chk("dwen_dren_exclusive", 64'(dwen & dren), 64'd0);
                chk("rx_ready_during_req", 64'(rx_ready), 64'd0);
                if (wait_left > 0) begin
                    dwait = 1'b1;
                    wait_left--;
                end else begin
                    dwait = 1'b0;
                    if (dwen) begin
                        obs_w.push_back('{daddr, dstore});
                        ram[daddr] = dstore;
                    end else begin
                        dload = ram.exists(daddr) ? ram[daddr] : 32'h0;
                    end
                end
            end else begin
                dwait     = 1'b0;
                wait_left = wait_cfg;
            end
            if (tx_valid && prev_tv && !prev_tr)
                chk("tx_data_stable", 64'(tx_data), 64'(prev_td));
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
            prev_tv = tx_valid;
            prev_tr = tx_ready;
            prev_td = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rx_ready && !tx_valid && !dwen && !dren) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(rx_ready && !tx_valid), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] cnt_raw, input string tag);
        int          n;
        logic [31:0] a;
        n = int'(cnt_raw & 32'h0000_FFFF);
        send_byte(8'h57);
        send_word(addr);
        send_word(cnt_raw);
        a = addr;
        for (int i = 0; i < n; i++) begin
            ref_mem[a] = wq[i];
            exp_w.push_back('{a, wq[i]});
            send_word(wq[i]);
            a = a + 32'd4;
        end
        wait_idle();
        chk({tag, "_nwrites"}, 64'(obs_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            chk({tag, "_write"}, obs_w[i], exp_w[i]);
        obs_w.delete();
        exp_w.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] cnt_raw, input string tag);
        int          n;
        logic [31:0] a, w;
        n = int'(cnt_raw & 32'h0000_FFFF);
        a = addr;
        for (int i = 0; i < n; i++) begin
            w = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
            a = a + 32'd4;
        end
        send_byte(8'h52);
        send_word(addr);
        send_word(cnt_raw);
        wait_idle();
        chk({tag, "_nbytes"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            chk({tag, "_byte"}, 64'(obs_tx[i]), 64'(exp_tx[i]));
        obs_tx.delete();
        exp_tx.delete();
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_override", 64'(override_ctrl), 64'd1);
        chk("rst_cpu_nrst", 64'(cpu_nrst), 64'd0);
        chk("rst_dwen", 64'(dwen), 64'd0);
        chk("rst_dren", 64'(dren), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("rst_iren", 64'(iren), 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        // write two words with three wait cycles each, then read them back
        wait_cfg = 3;
        wq = '{32'hDEADBEEF, 32'h12345678};
        do_write(32'h0000_0100, 32'd2, "t2");
        wait_cfg = 2;
        do_read(32'h0000_0100, 32'd2, "t3");

        // address wrap, zero count, oversized count
        wait_cfg = 12;
        wq = '{32'hA5A5_0001, 32'h5A5A_0002};
        do_write(32'hFFFF_FFFC, 32'd2, "t4_wrap");
        wait_cfg = 0;
        do_read(32'hFFFF_FFFC, 32'd2, "t4_wrap_rb");
        do_write(32'h0000_0300, 32'd0, "t4_zero");
        wq = '{$urandom, $urandom};
        do_write(32'h0000_0400, 32'h0003_0002, "t4_wide");
        do_read(32'h0000_0400, 32'h0001_0002, "t4_wide_rb");

        // randomized write/read-back rounds
        for (int r = 0; r < 6; r++) begin
            logic [31:0] base;
            int          cnt;
            base     = $urandom & 32'hFFFF_FFFC;
            cnt      = $urandom_range(1, 3);
            wait_cfg = $urandom_range(0, 3);
            wq.delete();
            for (int i = 0; i < cnt; i++) wq.push_back($urandom);
            do_write(base, 32'(cnt), "rnd_w");
            wait_cfg = $urandom_range(0, 3);
            do_read(base, 32'(cnt), "rnd_r");
        end

        // run / halt / unknown command
        send_byte(8'h47);
        chk("go_override", 64'(override_ctrl), 64'd0);
        chk("go_cpu_nrst", 64'(cpu_nrst), 64'd1);
        send_byte(8'h48);
        chk("halt_override", 64'(override_ctrl), 64'd1);
        chk("halt_cpu_nrst", 64'(cpu_nrst), 64'd0);
        chk("err_before_bad", 64'(err), 64'd0);
        send_byte(8'h00);
        chk("err_set", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);

        // asynchronous reset while a write is stalled
        wait_cfg = 1000;
        send_byte(8'h57);
        send_word(32'h0000_0500);
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        chk("stall_dwen", 64'(dwen), 64'd1);
        chk("stall_dstore", 64'(dstore), 64'hCAFE_F00D);
        #2 nrst = 1'b0;
        #1;
        chk("abort_dwen", 64'(dwen), 64'd0);
        chk("abort_override", 64'(override_ctrl), 64'd1);
        chk("abort_err", 64'(err), 64'd0);
        chk("abort_dstore", 64'(dstore), 64'd0);
        chk("abort_rx_ready", 64'(rx_ready), 64'd1);
        @(negedge clk);
        nrst = 1'b1;
        wait_cfg = 2;
        @(negedge clk);
        chk("abort_no_write", 64'(obs_w.size()), 64'd0);
        obs_w.delete();
        wq = '{32'h0BAD_C0DE};
        do_write(32'h0000_0500, 32'd1, "t6_after");
        do_read(32'h0000_0500, 32'd1, "t6_rb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no completion, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
